// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for the multiplexed 7-segment bus: waits for the scanned
// anode/segment lines to settle, decodes each digit and assembles 4-digit frames.
module seg7_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 524288
) (
   input  logic        clk_osc,
   input  logic        resetn,
   input  logic [3:0]  anode,
   input  logic [6:0]  seg,
   output logic [15:0] digits,
   output logic [3:0]  digit_seen,
   output logic [15:0] frame_digits,
   output logic        frame_valid,
   output logic [3:0]  blank_mask,
   output logic [3:0]  err_pattern,
   output logic        err_anode,
   output logic        display_dead
);

   localparam logic [1:0]  ST_IDLE     = 2'd0;
   localparam logic [1:0]  ST_SETTLING = 2'd1;
   localparam logic [1:0]  ST_HOLD     = 2'd2;

   localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYCLES);
   localparam logic [19:0] IDLE_MAX    = 20'hFFFFF;

   // Returns {blank, bad, code} for one segment pattern.
   function automatic logic [5:0] decodeSeg(input logic [6:0] pattern);
      logic [5:0] result;
      case (pattern)
         7'b0111111: result = {2'b00, 4'd0};
         7'b0000110: result = {2'b00, 4'd1};
         7'b1011011: result = {2'b00, 4'd2};
         7'b1001111: result = {2'b00, 4'd3};
         7'b1100110: result = {2'b00, 4'd4};
         7'b1101101: result = {2'b00, 4'd5};
         7'b1111101: result = {2'b00, 4'd6};
         7'b0000111: result = {2'b00, 4'd7};
         7'b1111111: result = {2'b00, 4'd8};
         7'b1101111: result = {2'b00, 4'd9};
         7'b0000000: result = {2'b10, 4'hF};
         default:    result = {2'b01, 4'hE};
      endcase
      return result;
   endfunction

   logic [10:0] sync1_q, sync2_q, prev_q;
   logic [1:0]  state_q, state_d;
   logic [7:0]  stableCnt_q, stableCnt_d;
   logic [19:0] idleCnt_q, idleCnt_d;
   logic [15:0] digits_q, digits_d;
   logic [3:0]  digitSeen_q, digitSeen_d;
   logic [15:0] frameDigits_q, frameDigits_d;
   logic        frameValid_q, frameValid_d;
   logic [3:0]  blankMask_q, blankMask_d;
   logic [3:0]  errPattern_q, errPattern_d;
   logic        errAnode_q, errAnode_d;

   logic [3:0]  syncAnode;
   logic [6:0]  syncSeg;
   logic        changed, captureEdge, validCapture;
   logic        anodeOne, anodeMulti;
   logic [1:0]  anodeIdx;
   logic [5:0]  decoded;
   logic [3:0]  seenMerged;

   assign syncAnode    = sync2_q[10:7];
   assign syncSeg      = sync2_q[6:0];
   assign changed      = (sync2_q != prev_q);
   assign captureEdge  = (state_q == ST_SETTLING) && !changed && (stableCnt_q == SETTLE_LAST);
   assign validCapture = captureEdge && anodeOne;
   assign decoded      = decodeSeg(syncSeg);

   always_ff @(posedge clk_osc or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= {anode, seg};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // All-off is a legitimate blanking slot; any other multi-low pattern is a bus fault.
   always_comb begin
      anodeOne   = 1'b0;
      anodeMulti = 1'b0;
      anodeIdx   = 2'd0;
      case (syncAnode)
         4'b1110: begin anodeOne = 1'b1; anodeIdx = 2'd0; end
         4'b1101: begin anodeOne = 1'b1; anodeIdx = 2'd1; end
         4'b1011: begin anodeOne = 1'b1; anodeIdx = 2'd2; end
         4'b0111: begin anodeOne = 1'b1; anodeIdx = 2'd3; end
         4'b1111: anodeMulti = 1'b0;
         default: anodeMulti = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      stableCnt_d   = stableCnt_q;
      idleCnt_d     = idleCnt_q;
      digits_d      = digits_q;
      digitSeen_d   = digitSeen_q;
      frameDigits_d = frameDigits_q;
      frameValid_d  = 1'b0;
      blankMask_d   = blankMask_q;
      errPattern_d  = errPattern_q;
      errAnode_d    = errAnode_q;
      seenMerged    = digitSeen_q | (4'b0001 << anodeIdx);

      if (changed) begin
         stableCnt_d = '0;
      end else if (stableCnt_q != SETTLE_MAX) begin
         stableCnt_d = stableCnt_q + 8'd1;
      end

      if (changed) begin
         state_d = ST_SETTLING;
      end else if (captureEdge) begin
         state_d = ST_HOLD;
         if (anodeMulti) begin
            errAnode_d = 1'b1;
         end
         if (anodeOne) begin
            digits_d[{anodeIdx, 2'b00} +: 4] = decoded[3:0];
            blankMask_d[anodeIdx] = decoded[5];
            if (decoded[4]) begin
               errPattern_d[anodeIdx] = 1'b1;
            end
            // The snapshot must include the code being captured on this same edge.
            if (seenMerged == 4'b1111) begin
               frameDigits_d = digits_d;
               frameValid_d  = 1'b1;
               digitSeen_d   = '0;
            end else begin
               digitSeen_d = seenMerged;
            end
         end
      end

      if (validCapture) begin
         idleCnt_d = '0;
      end else if (idleCnt_q != IDLE_MAX) begin
         idleCnt_d = idleCnt_q + 20'd1;
      end
   end

   always_ff @(posedge clk_osc or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         stableCnt_q   <= '0;
         idleCnt_q     <= '0;
         digits_q      <= '0;
         digitSeen_q   <= '0;
         frameDigits_q <= '0;
         frameValid_q  <= 1'b0;
         blankMask_q   <= '0;
         errPattern_q  <= '0;
         errAnode_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         stableCnt_q   <= stableCnt_d;
         idleCnt_q     <= idleCnt_d;
         digits_q      <= digits_d;
         digitSeen_q   <= digitSeen_d;
         frameDigits_q <= frameDigits_d;
         frameValid_q  <= frameValid_d;
         blankMask_q   <= blankMask_d;
         errPattern_q  <= errPattern_d;
         errAnode_q    <= errAnode_d;
      end
   end

   assign digits       = digits_q;
   assign digit_seen   = digitSeen_q;
   assign frame_digits = frameDigits_q;
   assign frame_valid  = frameValid_q;
   assign blank_mask   = blankMask_q;
   assign err_pattern  = errPattern_q;
   assign err_anode    = errAnode_q;
   assign display_dead = (idleCnt_q >= TIMEOUT_LIM);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a sample-window model of the display
// monitor is compared every cycle, plus hand-computed literal checks.
module tb_seg7_scan_decoder;

   localparam int SETTLE  = 16;
   localparam int TIMEOUT = 2000;

   logic        clk_osc;
   logic        resetn;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic [15:0] digits;
   logic [3:0]  digit_seen;
   logic [15:0] frame_digits;
   logic        frame_valid;
   logic [3:0]  blank_mask;
   logic [3:0]  err_pattern;
   logic        err_anode;
   logic        display_dead;

   seg7_scan_decoder #(
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_osc     (clk_osc),
      .resetn      (resetn),
      .anode       (anode),
      .seg         (seg),
      .digits      (digits),
      .digit_seen  (digit_seen),
      .frame_digits(frame_digits),
      .frame_valid (frame_valid),
      .blank_mask  (blank_mask),
      .err_pattern (err_pattern),
      .err_anode   (err_anode),
      .display_dead(display_dead)
   );

   localparam logic [6:0] P0 = 7'b0111111, P1 = 7'b0000110, P2 = 7'b1011011,
                          P3 = 7'b1001111, P4 = 7'b1100110, P5 = 7'b1101101,
                          P6 = 7'b1111101, P7 = 7'b0000111, P8 = 7'b1111111,
                          P9 = 7'b1101111;

   logic [6:0] pats [10] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

   int passCount  = 0;
   int checkCount = 0;
   int fvCount    = 0;
   int fvBase;

   // Model state: recent pin samples, newest at index 0.
   logic [10:0] hist [SETTLE+4];
   logic [15:0] mDigits, mFrame;
   logic [3:0]  mSeen, mBlank, mErrP;
   logic        mFv, mErrA;
   int          idleCnt;

   initial begin
      clk_osc = 1'b0;
      forever #5 clk_osc = ~clk_osc;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   task automatic applyStimulus(input logic [3:0] an, input logic [6:0] sg, input int cycles);
      @(negedge clk_osc);
      anode = an;
      seg   = sg;
      repeat (cycles) @(posedge clk_osc);
   endtask

   // A digit is taken when the pins held one value for SETTLE+1 samples
   // (seen two edges late through the synchronizer) after being different.
   task automatic modelStep();
      bit         window;
      int         lows, idx;
      logic [3:0] an, code, seen;
      logic [6:0] sg;
      bit         captured;
      if (!resetn) begin
         for (int j = 0; j < SETTLE + 4; j++) hist[j] = '0;
         mDigits = '0; mFrame = '0; mSeen = '0; mBlank = '0; mErrP = '0;
         mFv = 1'b0; mErrA = 1'b0; idleCnt = 0;
      end else begin
         for (int j = SETTLE + 3; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = {anode, seg};
         mFv = 1'b0;
         captured = 1'b0;
         window = (hist[SETTLE+3] != hist[SETTLE+2]);
         for (int j = 2; j < SETTLE + 2; j++) if (hist[j] != hist[j+1]) window = 1'b0;
         if (window) begin
            an = hist[2][10:7];
            sg = hist[2][6:0];
            lows = 0;
            idx = 0;
            for (int j = 0; j < 4; j++) if (!an[j]) begin lows++; idx = j; end
            if (lows > 1) mErrA = 1'b1;
            if (lows == 1) begin
               captured = 1'b1;
               code = 4'hE;
               for (int k = 0; k < 10; k++) if (pats[k] == sg) code = 4'(k);
               if (sg == 7'd0) code = 4'hF;
               mBlank[idx] = (sg == 7'd0);
               if (code == 4'hE) mErrP[idx] = 1'b1;
               mDigits[idx*4 +: 4] = code;
               seen = mSeen;
               seen[idx] = 1'b1;
               if (seen == 4'hF) begin
                  mFrame = mDigits;
                  mFv = 1'b1;
                  mSeen = '0;
               end else begin
                  mSeen = seen;
               end
            end
         end
         idleCnt = captured ? 0 : idleCnt + 1;
      end
   endtask

   task automatic compareLoop();
      forever begin
         @(posedge clk_osc);
         modelStep();
         #1;
         if (frame_valid) fvCount++;
         checkOutput("cycle",
            {17'd0, digits, digit_seen, frame_digits, frame_valid, blank_mask, err_pattern, err_anode, display_dead},
            {17'd0, mDigits, mSeen, mFrame, mFv, mBlank, mErrP, mErrA, (idleCnt >= TIMEOUT)});
      end
   endtask

   initial begin
      resetn = 1'b0;
      anode  = 4'hF;
      seg    = 7'd0;
      fork
         compareLoop();
      join_none

      repeat (3) @(posedge clk_osc);
      @(negedge clk_osc);
      checkOutput("reset_all", {digits, digit_seen, frame_digits, frame_valid, blank_mask, err_pattern, err_anode, display_dead}, 64'd0);
      resetn = 1'b1;
      applyStimulus(4'hF, 7'd0, 30);

      $display("[TB] scan 1234");
      fvBase = fvCount;
      applyStimulus(4'b1110, P4, 64);
      @(negedge clk_osc);
      checkOutput("first_digit", {digits, digit_seen}, {16'h0004, 4'b0001});
      applyStimulus(4'b1101, P3, 64);
      applyStimulus(4'b1011, P2, 64);
      applyStimulus(4'b0111, P1, 64);
      @(negedge clk_osc);
      checkOutput("digits_1234", digits, 16'h1234);
      checkOutput("frame_1234", frame_digits, 16'h1234);
      checkOutput("seen_cleared", digit_seen, 4'b0000);
      checkOutput("one_frame_pulse", fvCount - fvBase, 1);

      $display("[TB] settle latency");
      @(negedge clk_osc);
      anode = 4'b1110;
      seg   = P9;
      repeat (SETTLE + 2) @(posedge clk_osc);
      @(negedge clk_osc);
      checkOutput("not_yet", digits[3:0], 4'd4);
      @(posedge clk_osc);
      @(negedge clk_osc);
      checkOutput("latency_edge", digits[3:0], 4'd9);
      repeat (40) @(posedge clk_osc);

      $display("[TB] short glitch");
      applyStimulus(4'b1110, P8, SETTLE - 2);
      applyStimulus(4'b1110, P9, 40);
      @(negedge clk_osc);
      checkOutput("glitch_ignored", digits[3:0], 4'd9);

      $display("[TB] bad pattern");
      applyStimulus(4'b0111, 7'b1010101, 64);
      @(negedge clk_osc);
      checkOutput("bad_code", digits[15:12], 4'hE);
      checkOutput("err_pattern", err_pattern, 4'b1000);
      applyStimulus(4'b1110, P8, 64);
      applyStimulus(4'b1101, P7, 64);
      applyStimulus(4'b1011, P6, 64);
      applyStimulus(4'b0111, P5, 64);
      @(negedge clk_osc);
      checkOutput("digits_5678", digits, 16'h5678);
      checkOutput("frame_E678", frame_digits, 16'hE678);
      checkOutput("seen_after", digit_seen, 4'b1000);
      checkOutput("err_sticky", err_pattern, 4'b1000);

      $display("[TB] anode faults, blank, timeout");
      applyStimulus(4'b1100, P8, 64);
      @(negedge clk_osc);
      checkOutput("err_anode", err_anode, 1'b1);
      checkOutput("digits_kept", digits, 16'h5678);
      applyStimulus(4'b1110, 7'd0, 64);
      @(negedge clk_osc);
      checkOutput("blank_code", digits, 16'h567F);
      checkOutput("blank_mask", blank_mask, 4'b0001);
      applyStimulus(4'hF, 7'd0, TIMEOUT + 100);
      @(negedge clk_osc);
      checkOutput("dead_set", display_dead, 1'b1);
      checkOutput("no_anode_err_change", {err_anode, err_pattern}, {1'b1, 4'b1000});
      @(negedge clk_osc);
      anode = 4'b1110;
      seg   = P1;
      repeat (SETTLE + 2) @(posedge clk_osc);
      @(negedge clk_osc);
      checkOutput("dead_before_capture", display_dead, 1'b1);
      @(posedge clk_osc);
      @(negedge clk_osc);
      checkOutput("dead_cleared", display_dead, 1'b0);
      checkOutput("blank_cleared", blank_mask, 4'b0000);
      repeat (40) @(posedge clk_osc);

      $display("[TB] reset mid-frame");
      applyStimulus(4'b1011, P7, 64);
      applyStimulus(4'b1101, P3, 64);
      applyStimulus(4'b1110, P2, 64);
      applyStimulus(4'b1101, P3, 64);
      @(negedge clk_osc);
      checkOutput("two_seen", digit_seen, 4'b0011);
      applyStimulus(4'b1011, P2, 8);
      @(negedge clk_osc);
      resetn = 1'b0;
      repeat (2) @(posedge clk_osc);
      @(negedge clk_osc);
      checkOutput("reset_mid", {digits, digit_seen, frame_digits, frame_valid, blank_mask, err_pattern, err_anode, display_dead}, 64'd0);
      resetn = 1'b1;
      fvBase = fvCount;
      applyStimulus(4'b1011, P2, 64);
      @(negedge clk_osc);
      checkOutput("post_reset_capture", digits, 16'h0200);
      applyStimulus(4'b0111, P1, 64);
      applyStimulus(4'b1110, P4, 64);
      @(negedge clk_osc);
      checkOutput("no_early_frame", fvCount - fvBase, 0);
      checkOutput("three_seen", digit_seen, 4'b1101);
      applyStimulus(4'b1101, P3, 64);
      @(negedge clk_osc);
      checkOutput("frame_after_reset", fvCount - fvBase, 1);
      checkOutput("frame_digits_reset", frame_digits, 16'h1234);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
